// File: rtl/game_ctrl_fsm_if.sv
// Game controller bus: raw/strobe inputs from the board and physics, game status outputs.
// master drives the inputs (top level / bench), slave is the controller.
interface game_ctrl_fsm_if #(
  parameter int SCORE_W = 10
);
  logic               tick;
  logic               flap_button;
  logic               paused;
  logic               collision;
  logic               pipe_passed;
  logic [1:0]         game_state;
  logic               game_rst;
  logic               game_tick_en;
  logic               flap_pulse;
  logic [SCORE_W-1:0] current_score;
  logic [SCORE_W-1:0] highest_score;

  modport master (
    output tick, flap_button, paused, collision, pipe_passed,
    input  game_state, game_rst, game_tick_en, flap_pulse, current_score, highest_score
  );

  modport slave (
    input  tick, flap_button, paused, collision, pipe_passed,
    output game_state, game_rst, game_tick_en, flap_pulse, current_score, highest_score
  );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Flappy Bird game sequencer: IDLE/PLAY/PAUSE/OVER FSM, flap conditioning, tick gating, scores.
// Define FLAP_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter on the synchronised flap level.
module game_ctrl_fsm #(
  parameter int SCORE_W         = 10,
  parameter int SCORE_MAX       = 999,
  parameter int DEAD_TICKS      = 50,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           clr,
  game_ctrl_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [SCORE_W-1:0] SCORE_MAX_C  = SCORE_W'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] DEAD_TICKS_C = SCORE_W'(DEAD_TICKS);

  state_e             state_q;
  logic               flap_s1_q;
  logic               flap_s2_q;
  logic               pause_s1_q;
  logic               pause_s2_q;
  logic               flap_lvl_q;
  logic               game_rst_q;
  logic               flap_pulse_q;
  logic [SCORE_W-1:0] cur_q;
  logic [SCORE_W-1:0] high_q;
  logic [SCORE_W-1:0] dead_q;
  logic               flap_filt;
  logic               press;

`ifdef FLAP_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            filt_q;
  logic [DB_W-1:0] db_cnt_q;

  // The filtered level follows the synchronised level only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts.
  always_ff @(posedge clk) begin
    if (clr) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else if (flap_s2_q == filt_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      filt_q   <= flap_s2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign flap_filt = filt_q;
`else
  assign flap_filt = flap_s2_q;
`endif

  assign press = flap_filt & ~flap_lvl_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      flap_s1_q    <= 1'b0;
      flap_s2_q    <= 1'b0;
      pause_s1_q   <= 1'b0;
      pause_s2_q   <= 1'b0;
      flap_lvl_q   <= 1'b0;
      game_rst_q   <= 1'b1;
      flap_pulse_q <= 1'b0;
      cur_q        <= '0;
      high_q       <= '0;
      dead_q       <= '0;
    end else begin
      flap_s1_q    <= bus.flap_button;
      flap_s2_q    <= flap_s1_q;
      pause_s1_q   <= bus.paused;
      pause_s2_q   <= pause_s1_q;
      flap_lvl_q   <= flap_filt;
      game_rst_q   <= 1'b0;
      flap_pulse_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // The starting press launches the run and is not a flap.
          if (press) begin
            state_q    <= ST_PLAY;
            game_rst_q <= 1'b1;
            cur_q      <= '0;
          end
        end
        ST_PLAY: begin
          if (bus.collision) begin
            state_q <= ST_OVER;
            high_q  <= (cur_q > high_q) ? cur_q : high_q;
            dead_q  <= DEAD_TICKS_C;
          end else begin
            if (pause_s2_q) begin
              state_q <= ST_PAUSE;
            end else begin
              flap_pulse_q <= press;
            end
            if (bus.pipe_passed && (cur_q < SCORE_MAX_C)) begin
              cur_q <= cur_q + SCORE_W'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (!pause_s2_q) begin
            state_q <= ST_PLAY;
          end
        end
        ST_OVER: begin
          // Presses are swallowed until the dead time has run out.
          if (dead_q != '0) begin
            if (bus.tick) begin
              dead_q <= dead_q - SCORE_W'(1);
            end
          end else if (press) begin
            state_q    <= ST_IDLE;
            game_rst_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.game_state    = state_q;
  assign bus.game_rst      = game_rst_q;
  assign bus.game_tick_en  = bus.tick & (state_q == ST_PLAY);
  assign bus.flap_pulse    = flap_pulse_q;
  assign bus.current_score = cur_q;
  assign bus.highest_score = high_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm: DEAD_TICKS=3, DEBOUNCE_CYCLES=4, tick every 10 clk.
module tb_game_ctrl_fsm;

  localparam int SCORE_W = 10;
`ifdef FLAP_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;
  int   flap_cnt;
  int   tick_total;
  int   tick_en_bad;
  int   base;
  int   fc;
  int   ph;

  game_ctrl_fsm_if #(.SCORE_W(SCORE_W)) bus ();

  game_ctrl_fsm #(
    .SCORE_W(SCORE_W),
    .SCORE_MAX(999),
    .DEAD_TICKS(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick strobe changes 2 time units after posedge, one clk wide every 10 clk.
  initial begin
    bus.tick = 1'b0;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.tick = (ph == 9);
      ph = (ph == 9) ? 0 : ph + 1;
    end
  end

  initial begin
    flap_cnt    = 0;
    tick_total  = 0;
    tick_en_bad = 0;
  end

  always @(posedge clk) begin
    if (bus.flap_pulse === 1'b1) flap_cnt <= flap_cnt + 1;
    if (bus.tick === 1'b1) tick_total <= tick_total + 1;
  end

  always @(negedge clk) begin
    if (bus.game_tick_en !== (bus.tick & (bus.game_state == 2'd1)))
      tick_en_bad <= tick_en_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pipe(input int n);
    repeat (n) begin
      bus.pipe_passed = 1'b1;
      cyc(1);
      bus.pipe_passed = 1'b0;
      cyc(1);
    end
  endtask

  task automatic tap();
    bus.flap_button = 1'b1;
    cyc(LAT + 2);
    bus.flap_button = 1'b0;
    cyc(LAT + 2);
  endtask

  task automatic wait_dead(input int b);
    for (int i = 0; i < 200 && tick_total < b + 3; i++) cyc(1);
    chk("dead_ticks_seen", 32'(tick_total >= b + 3), 32'd1);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 25 && bus.tick !== 1'b1; i++) cyc(1);
    chk("tick_seen", 32'(bus.tick), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr = 1'b1;
    bus.flap_button = 1'b0;
    bus.paused      = 1'b0;
    bus.collision   = 1'b0;
    bus.pipe_passed = 1'b0;

    // Reset
    cyc(1);
    chk("rst_state", 32'(bus.game_state), 32'd0);
    chk("rst_game_rst", 32'(bus.game_rst), 32'd1);
    chk("rst_cur", 32'(bus.current_score), 32'd0);
    chk("rst_high", 32'(bus.highest_score), 32'd0);
    chk("rst_flap", 32'(bus.flap_pulse), 32'd0);
    clr = 1'b0;
    cyc(1);
    chk("rst_game_rst_drop", 32'(bus.game_rst), 32'd0);
    cyc(20);
    chk("idle_stays", 32'(bus.game_state), 32'd0);

    // IDLE -> PLAY, starting press not forwarded
    bus.flap_button = 1'b1;
    cyc(LAT - 1);
    chk("idle_before_lat", 32'(bus.game_state), 32'd0);
    cyc(1);
    chk("start_state", 32'(bus.game_state), 32'd1);
    chk("start_game_rst", 32'(bus.game_rst), 32'd1);
    cyc(1);
    chk("start_game_rst_drop", 32'(bus.game_rst), 32'd0);
    bus.flap_button = 1'b0;
    cyc(LAT + 2);
    chk("start_no_flap", 32'(flap_cnt), 32'd0);

    // Flap latency and hold
    bus.flap_button = 1'b1;
    cyc(LAT - 1);
    chk("flap_early", 32'(bus.flap_pulse), 32'd0);
    cyc(1);
    chk("flap_at_lat", 32'(bus.flap_pulse), 32'd1);
    cyc(1);
    chk("flap_one_clk", 32'(bus.flap_pulse), 32'd0);
    cyc(100);
    chk("flap_hold_once", 32'(flap_cnt), 32'd1);
    bus.flap_button = 1'b0;
    cyc(LAT + 2);

    // Scoring, collision outranks pipe_passed
    pulse_pipe(5);
    chk("score5", 32'(bus.current_score), 32'd5);
    bus.pipe_passed = 1'b1;
    bus.collision   = 1'b1;
    cyc(1);
    bus.pipe_passed = 1'b0;
    bus.collision   = 1'b0;
    chk("over_state", 32'(bus.game_state), 32'd3);
    chk("over_cur", 32'(bus.current_score), 32'd5);
    chk("over_high", 32'(bus.highest_score), 32'd5);

    // Dead time in OVER
    base = tick_total;
    tap();
    chk("over_early_press", 32'(bus.game_state), 32'd3);
    wait_dead(base);
    bus.flap_button = 1'b1;
    cyc(LAT);
    chk("over_to_idle", 32'(bus.game_state), 32'd0);
    chk("over_game_rst", 32'(bus.game_rst), 32'd1);
    cyc(1);
    chk("over_game_rst_drop", 32'(bus.game_rst), 32'd0);
    bus.flap_button = 1'b0;
    cyc(LAT + 2);
    tap();
    chk("run2_state", 32'(bus.game_state), 32'd1);
    chk("run2_cur_clear", 32'(bus.current_score), 32'd0);
    pulse_pipe(2);
    bus.collision = 1'b1;
    cyc(1);
    bus.collision = 1'b0;
    chk("run2_over", 32'(bus.game_state), 32'd3);
    chk("run2_cur", 32'(bus.current_score), 32'd2);
    chk("run2_high", 32'(bus.highest_score), 32'd5);

    // Pause
    base = tick_total;
    wait_dead(base);
    tap();
    chk("run3_idle", 32'(bus.game_state), 32'd0);
    tap();
    chk("run3_play", 32'(bus.game_state), 32'd1);
    pulse_pipe(1);
    chk("run3_cur1", 32'(bus.current_score), 32'd1);
    bus.paused = 1'b1;
    cyc(2);
    chk("pause_sync_wait", 32'(bus.game_state), 32'd1);
    cyc(1);
    chk("pause_entered", 32'(bus.game_state), 32'd2);
    fc = flap_cnt;
    tap();
    pulse_pipe(3);
    bus.collision = 1'b1;
    cyc(1);
    bus.collision = 1'b0;
    chk("pause_ignores_collision", 32'(bus.game_state), 32'd2);
    chk("pause_score_held", 32'(bus.current_score), 32'd1);
    chk("pause_no_flap", 32'(flap_cnt), 32'(fc));
    wait_tick();
    chk("pause_tick_gated", 32'(bus.game_tick_en), 32'd0);
    bus.paused = 1'b0;
    cyc(2);
    chk("resume_sync_wait", 32'(bus.game_state), 32'd2);
    cyc(1);
    chk("resumed", 32'(bus.game_state), 32'd1);
    chk("resume_score", 32'(bus.current_score), 32'd1);
    wait_tick();
    chk("play_tick_en", 32'(bus.game_tick_en), 32'd1);

`ifdef FLAP_DEBOUNCE_EN
    // Debounce: 3-clk glitch rejected, 4-clk level accepted
    fc = flap_cnt;
    bus.flap_button = 1'b1;
    cyc(3);
    bus.flap_button = 1'b0;
    cyc(12);
    chk("glitch_rejected", 32'(flap_cnt), 32'(fc));
    bus.flap_button = 1'b1;
    cyc(4);
    bus.flap_button = 1'b0;
    cyc(12);
    chk("stable_accepted", 32'(flap_cnt), 32'(fc + 1));
`endif

    // Saturation
    bus.pipe_passed = 1'b1;
    cyc(997);
    bus.pipe_passed = 1'b0;
    chk("score998", 32'(bus.current_score), 32'd998);
    pulse_pipe(3);
    chk("score_sat", 32'(bus.current_score), 32'd999);
    bus.collision = 1'b1;
    cyc(1);
    bus.collision = 1'b0;
    chk("sat_over", 32'(bus.game_state), 32'd3);
    chk("sat_high", 32'(bus.highest_score), 32'd999);

    // clr while OVER clears everything
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_state", 32'(bus.game_state), 32'd0);
    chk("clr_high", 32'(bus.highest_score), 32'd0);
    chk("clr_cur", 32'(bus.current_score), 32'd0);
    chk("clr_game_rst", 32'(bus.game_rst), 32'd1);
    cyc(2);
    chk("tick_en_gating", 32'(tick_en_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
